// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM command controller: command codes, one-hot
// state encoding, status bit positions and the registered control-output bundle.
package rram_ctrl_pkg;

  localparam logic [3:0] CMD_READ = 4'b0001;
  localparam logic [3:0] CMD_WR1  = 4'b0100;
  localparam logic [3:0] CMD_WR2  = 4'b0010;
  localparam logic [3:0] CMD_FM1  = 4'b0111;
  localparam logic [3:0] CMD_FM2  = 4'b0110;
  localparam logic [3:0] CMD_ER1  = 4'b0011;
  localparam logic [3:0] CMD_ER2  = 4'b1101;
  localparam logic [3:0] CMD_STAT = 4'b1000;
  localparam logic [3:0] CMD_RST  = 4'b1111;

  typedef enum logic [13:0] {
    S_IDLE     = 14'h0001,
    S_RD_ADDR  = 14'h0002,
    S_RD_ARRAY = 14'h0004,
    S_RD_OUT   = 14'h0008,
    S_WR_ADDR  = 14'h0010,
    S_WR_LOAD  = 14'h0020,
    S_WR_ARRAY = 14'h0040,
    S_WR_RETRY = 14'h0080,
    S_FM_CMD2  = 14'h0100,
    S_FM_ARRAY = 14'h0200,
    S_ER_ADDR  = 14'h0400,
    S_ER_CMD2  = 14'h0800,
    S_ER_ARRAY = 14'h1000,
    S_ST_OUT   = 14'h2000
  } state_e;

  localparam logic [13:0] ARRAY_MASK = 14'h1244;

  localparam int STAT_READY   = 7;
  localparam int STAT_FAIL    = 6;
  localparam int STAT_TIMEOUT = 5;
  localparam int STAT_ABORT   = 4;

  typedef struct packed {
    logic we_rw;
    logic re_rw;
    logic form_rw;
    logic erase_rw;
    logic we_l;
    logic re_l;
    logic en_decoder;
    logic en_count;
    logic rb;
  } ctrl_out_t;

  localparam ctrl_out_t OUT_IDLE = 9'b0_0000_0001;

  function automatic logic is_array(input state_e s);
    return |(14'(s) & ARRAY_MASK);
  endfunction

endpackage

// File: rtl/rram_op_timer.sv
// Array-operation watchdog: counts cycles spent in array states and flags
// expiry on the TO_CYC-th cycle; saturates so it stays expired until cleared.
module rram_op_timer #(
  parameter int TO_W   = 16,
  parameter int TO_CYC = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LP_LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  assign o_expired = (r_cnt >= LP_LAST);

  // Cycle counter, cleared on array entry and held outside array states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + TO_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/rram_cmd_ctrl.sv
// RRAM command/sequencing FSM: decodes two-phase commands, drives the array
// engine enables, and tracks program-verify retries, timeout and status.
module rram_cmd_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int TO_W      = 16,
  parameter int TO_CYC    = 4000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CE,
  input  logic       ALE,
  input  logic       CLE,
  input  logic [3:0] cmd,
  input  logic       cmd_ready,
  input  logic       addr_ready,
  input  logic       op_done,
  input  logic       verify_ok,
  output logic       we_rw,
  output logic       re_rw,
  output logic       form_rw,
  output logic       erase_rw,
  output logic       WE_L,
  output logic       RE_L,
  output logic       en_decoder,
  output logic       en_count,
  output logic       RB,
  output logic [7:0] status
);

  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  state_e    r_state;
  state_e    w_next;
  ctrl_out_t r_out;
  ctrl_out_t w_out;
  logic      r_fail, r_timeout, r_abort;
  logic      w_fail_n, w_to_n, w_abort_n;
  logic [3:0] r_retry, w_retry_n;
  logic      w_cmd_acc, w_rst_cmd, w_new_op, w_addr_ok;
  logic      w_in_array, w_clr_timer, w_expired;

  assign w_cmd_acc  = cmd_ready && CLE && !CE;
  // A reset command is honoured even while CE is high so it outranks the abort path
  assign w_rst_cmd  = cmd_ready && CLE && (cmd == CMD_RST);
  assign w_new_op   = w_cmd_acc && ((cmd == CMD_READ) || (cmd == CMD_WR1) ||
                                    (cmd == CMD_FM1)  || (cmd == CMD_ER1));
  assign w_addr_ok  = addr_ready && ALE;
  assign w_in_array = is_array(r_state);
  // The retry gap resumes the same program, so only a fresh entry restarts the watchdog
  assign w_clr_timer = is_array(w_next) && !w_in_array && (r_state != S_WR_RETRY);

  rram_op_timer #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clr_timer),
    .i_enable  (w_in_array),
    .o_expired (w_expired)
  );

  // Next-state and status-flag decode
  always_comb begin
    w_next    = r_state;
    w_fail_n  = r_fail;
    w_to_n    = r_timeout;
    w_abort_n = r_abort;
    w_retry_n = r_retry;
    if (w_rst_cmd) begin
      w_next    = S_IDLE;
      w_fail_n  = 1'b0;
      w_to_n    = 1'b0;
      w_abort_n = 1'b0;
      w_retry_n = 4'd0;
    end else if (CE) begin
      w_next = S_IDLE;
      if (w_in_array || (r_state == S_WR_RETRY)) begin
        w_abort_n = 1'b1;
      end else begin
        w_abort_n = r_abort;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_new_op) begin
            w_fail_n  = 1'b0;
            w_to_n    = 1'b0;
            w_abort_n = 1'b0;
            w_retry_n = 4'd0;
          end else begin
            w_retry_n = r_retry;
          end
          if (w_cmd_acc) begin
            case (cmd)
              CMD_READ: w_next = S_RD_ADDR;
              CMD_WR1:  w_next = S_WR_ADDR;
              CMD_FM1:  w_next = S_FM_CMD2;
              CMD_ER1:  w_next = S_ER_ADDR;
              CMD_STAT: w_next = S_ST_OUT;
              default:  w_next = S_IDLE;
            endcase
          end else begin
            w_next = S_IDLE;
          end
        end
        S_RD_ADDR: w_next = w_addr_ok ? S_RD_ARRAY : S_RD_ADDR;
        S_RD_ARRAY: begin
          if (op_done) begin
            w_next = S_RD_OUT;
          end else if (w_expired) begin
            w_next   = S_IDLE;
            w_fail_n = 1'b1;
            w_to_n   = 1'b1;
          end else begin
            w_next = S_RD_ARRAY;
          end
        end
        S_RD_OUT, S_ST_OUT: w_next = r_state;
        S_WR_ADDR: w_next = w_addr_ok ? S_WR_LOAD : S_WR_ADDR;
        S_WR_LOAD: w_next = (w_cmd_acc && (cmd == CMD_WR2)) ? S_WR_ARRAY : S_WR_LOAD;
        S_WR_ARRAY: begin
          if (op_done) begin
            if (verify_ok) begin
              w_next = S_IDLE;
            end else if (r_retry < LP_MAX_RETRY) begin
              w_next    = S_WR_RETRY;
              w_retry_n = r_retry + 4'd1;
            end else begin
              w_next   = S_IDLE;
              w_fail_n = 1'b1;
            end
          end else if (w_expired) begin
            w_next   = S_IDLE;
            w_fail_n = 1'b1;
            w_to_n   = 1'b1;
          end else begin
            w_next = S_WR_ARRAY;
          end
        end
        S_WR_RETRY: w_next = S_WR_ARRAY;
        S_FM_CMD2: w_next = (w_cmd_acc && (cmd == CMD_FM2)) ? S_FM_ARRAY : S_FM_CMD2;
        S_FM_ARRAY, S_ER_ARRAY: begin
          if (op_done) begin
            w_next = S_IDLE;
          end else if (w_expired) begin
            w_next   = S_IDLE;
            w_fail_n = 1'b1;
            w_to_n   = 1'b1;
          end else begin
            w_next = r_state;
          end
        end
        S_ER_ADDR: w_next = w_addr_ok ? S_ER_CMD2 : S_ER_ADDR;
        S_ER_CMD2: w_next = (w_cmd_acc && (cmd == CMD_ER2)) ? S_ER_ARRAY : S_ER_CMD2;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Control outputs decoded from the upcoming state so they switch with it
  always_comb begin
    w_out = OUT_IDLE;
    case (w_next)
      S_RD_ARRAY: begin
        w_out.re_rw = 1'b1; w_out.en_decoder = 1'b1; w_out.en_count = 1'b1; w_out.rb = 1'b0;
      end
      S_RD_OUT: begin
        w_out.re_l = 1'b1; w_out.en_count = 1'b1;
      end
      S_WR_LOAD: w_out.we_l = 1'b1;
      S_WR_ARRAY: begin
        w_out.we_rw = 1'b1; w_out.en_decoder = 1'b1; w_out.en_count = 1'b1; w_out.rb = 1'b0;
      end
      S_WR_RETRY: w_out.rb = 1'b0;
      S_FM_ARRAY: begin
        w_out.form_rw = 1'b1; w_out.en_decoder = 1'b1; w_out.en_count = 1'b1; w_out.rb = 1'b0;
      end
      S_ER_ARRAY: begin
        w_out.erase_rw = 1'b1; w_out.en_decoder = 1'b1; w_out.en_count = 1'b1; w_out.rb = 1'b0;
      end
      S_ST_OUT: w_out.re_l = 1'b1;
      default:  w_out = OUT_IDLE;
    endcase
  end

  // State, control outputs and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_out     <= OUT_IDLE;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
      r_retry   <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_out     <= w_out;
      r_fail    <= w_fail_n;
      r_timeout <= w_to_n;
      r_abort   <= w_abort_n;
      r_retry   <= w_retry_n;
    end
  end

  assign we_rw      = r_out.we_rw;
  assign re_rw      = r_out.re_rw;
  assign form_rw    = r_out.form_rw;
  assign erase_rw   = r_out.erase_rw;
  assign WE_L       = r_out.we_l;
  assign RE_L       = r_out.re_l;
  assign en_decoder = r_out.en_decoder;
  assign en_count   = r_out.en_count;
  assign RB         = r_out.rb;

  // Status byte assembly; ready mirrors RB
  always_comb begin
    status               = 8'h00;
    status[STAT_READY]   = r_out.rb;
    status[STAT_FAIL]    = r_fail;
    status[STAT_TIMEOUT] = r_timeout;
    status[STAT_ABORT]   = r_abort;
    status[3:0]          = r_retry;
  end

endmodule

// File: tb/tb_rram_cmd_ctrl.sv
// Self-checking bench for rram_cmd_ctrl: a transaction-level model predicts all
// outputs every cycle, and directed scenarios pin key results with literals.
module tb_rram_cmd_ctrl;

  localparam int TO_CYC    = 20;
  localparam int MAX_RETRY = 3;

  localparam logic [3:0] C_READ = 4'b0001, C_WR1 = 4'b0100, C_WR2 = 4'b0010;
  localparam logic [3:0] C_FM1  = 4'b0111, C_FM2 = 4'b0110, C_ER1 = 4'b0011;
  localparam logic [3:0] C_ER2  = 4'b1101, C_STAT = 4'b1000, C_RST = 4'b1111;

  localparam int OP_NONE = 0, OP_RD = 1, OP_WR = 2, OP_FM = 3, OP_ER = 4, OP_ST = 5;
  localparam int P_NONE = 0, P_ADDR = 1, P_CMD2 = 2, P_LOAD = 3, P_ARR = 4, P_GAP = 5, P_OUT = 6;

  logic clk = 1'b0, rst_n = 1'b0, CE = 1'b0, ALE = 1'b0, CLE = 1'b0;
  logic cmd_ready = 1'b0, addr_ready = 1'b0, op_done = 1'b0, verify_ok = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic we_rw, re_rw, form_rw, erase_rw, WE_L, RE_L, en_decoder, en_count, RB;
  logic [7:0] status;

  int n_checks = 0, n_errors = 0;
  int rb_low_cnt = 0, gap_cnt = 0, wel_cnt = 0, we_cnt = 0;

  int m_op, m_phase, m_arr, m_ret;
  bit m_fail, m_to, m_ab;

  rram_cmd_ctrl #(.TO_W(16), .TO_CYC(TO_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .CE(CE), .ALE(ALE), .CLE(CLE), .cmd(cmd),
    .cmd_ready(cmd_ready), .addr_ready(addr_ready), .op_done(op_done), .verify_ok(verify_ok),
    .we_rw(we_rw), .re_rw(re_rw), .form_rw(form_rw), .erase_rw(erase_rw),
    .WE_L(WE_L), .RE_L(RE_L), .en_decoder(en_decoder), .en_count(en_count),
    .RB(RB), .status(status)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_op = OP_NONE; m_phase = P_NONE; m_arr = 0; m_ret = 0;
    m_fail = 1'b0; m_to = 1'b0; m_ab = 1'b0;
  endtask

  task automatic model_idle();
    m_op = OP_NONE; m_phase = P_NONE;
  endtask

  task automatic model_step();
    bit acc, rstc;
    acc  = cmd_ready && CLE && !CE;
    rstc = cmd_ready && CLE && (cmd == C_RST);
    if (rstc) begin
      model_reset();
    end else if (CE) begin
      if (m_phase == P_ARR || m_phase == P_GAP) m_ab = 1'b1;
      model_idle();
    end else if (m_op == OP_NONE) begin
      if (acc) begin
        if (cmd inside {C_READ, C_WR1, C_FM1, C_ER1}) begin
          m_fail = 1'b0; m_to = 1'b0; m_ab = 1'b0; m_ret = 0;
        end
        case (cmd)
          C_READ: begin m_op = OP_RD; m_phase = P_ADDR; end
          C_WR1:  begin m_op = OP_WR; m_phase = P_ADDR; end
          C_FM1:  begin m_op = OP_FM; m_phase = P_CMD2; end
          C_ER1:  begin m_op = OP_ER; m_phase = P_ADDR; end
          C_STAT: begin m_op = OP_ST; m_phase = P_OUT; end
          default: ;
        endcase
      end
    end else begin
      case (m_phase)
        P_ADDR: if (addr_ready && ALE) begin
          if (m_op == OP_RD) begin m_phase = P_ARR; m_arr = 0; end
          else if (m_op == OP_WR) m_phase = P_LOAD;
          else m_phase = P_CMD2;
        end
        P_CMD2: if (acc && ((m_op == OP_FM && cmd == C_FM2) || (m_op == OP_ER && cmd == C_ER2))) begin
          m_phase = P_ARR; m_arr = 0;
        end
        P_LOAD: if (acc && cmd == C_WR2) begin m_phase = P_ARR; m_arr = 0; end
        P_GAP: m_phase = P_ARR;
        P_ARR: begin
          m_arr++;
          if (op_done) begin
            if (m_op == OP_RD) m_phase = P_OUT;
            else if (m_op == OP_WR && !verify_ok && m_ret < MAX_RETRY) begin
              m_ret++; m_phase = P_GAP;
            end else begin
              if (m_op == OP_WR && !verify_ok) m_fail = 1'b1;
              model_idle();
            end
          end else if (m_arr >= TO_CYC) begin
            m_fail = 1'b1; m_to = 1'b1; model_idle();
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [16:0] model_out();
    logic we, re, fm, er, wl, rl, dec, cnt, rb;
    logic [3:0] r;
    {we, re, fm, er, wl, rl, dec, cnt} = 8'h00;
    rb = 1'b1;
    if (m_phase == P_ARR) begin
      rb = 1'b0; dec = 1'b1; cnt = 1'b1;
      we = (m_op == OP_WR); re = (m_op == OP_RD); fm = (m_op == OP_FM); er = (m_op == OP_ER);
    end else if (m_phase == P_GAP) begin
      rb = 1'b0;
    end else if (m_phase == P_OUT) begin
      rl = 1'b1; cnt = (m_op == OP_RD);
    end else if (m_phase == P_LOAD) begin
      wl = 1'b1;
    end
    r = m_ret[3:0];
    return {we, re, fm, er, wl, rl, dec, cnt, rb, rb, m_fail, m_to, m_ab, r};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [16:0] got, exp;
    forever begin
      @(negedge clk);
      got = {we_rw, re_rw, form_rw, erase_rw, WE_L, RE_L, en_decoder, en_count, RB, status};
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
      end
      if (RB === 1'b0) rb_low_cnt++;
      if (RB === 1'b0 && {we_rw, re_rw, form_rw, erase_rw} === 4'b0000) gap_cnt++;
      if (WE_L === 1'b1) wel_cnt++;
      if (we_rw === 1'b1) we_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic cr, cl, ar, al, od, vk, input logic [3:0] c);
    @(posedge clk); #2;
    cmd_ready = cr; CLE = cl; addr_ready = ar; ALE = al; op_done = od; verify_ok = vk; cmd = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic send(input logic [3:0] c); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c); endtask
  task automatic addr(); drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0); endtask
  task automatic done(input logic vk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, vk, 4'h0); endtask
  task automatic settle(); idle(1); @(negedge clk); endtask

  task automatic ce_pulse();
    idle(1); CE = 1'b1;
    @(posedge clk); #2; CE = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_status", status, 8'h80);
    check("reset_rb", RB, 1'b1);

    // read: 10 busy cycles, then data out until CE
    rb_low_cnt = 0;
    send(C_READ); addr(); idle(9); done(1'b0);
    settle();
    check("read_busy_cycles", rb_low_cnt, 10);
    check("read_re_l", RE_L, 1'b1);
    check("read_rb", RB, 1'b1);
    ce_pulse();
    check("read_ce_idle_re_l", RE_L, 1'b0);

    // program pass
    wel_cnt = 0; we_cnt = 0;
    send(C_WR1); addr(); idle(3); send(C_WR2); idle(2); done(1'b1);
    settle();
    check("prog_pass_status", status, 8'h80);
    check("prog_pass_we_l_cycles", wel_cnt, 4);
    check("prog_pass_we_rw_cycles", we_cnt, 3);

    // program with all verifies failing
    gap_cnt = 0;
    send(C_WR1); addr(); send(C_WR2); idle(1); done(1'b0);
    repeat (3) begin idle(2); done(1'b0); end
    settle();
    check("prog_fail_status", status, 8'hC3);
    check("prog_fail_gaps", gap_cnt, 3);

    // status readout preserves flags
    send(C_STAT); settle();
    check("stat_re_l", RE_L, 1'b1);
    check("stat_status", status, 8'hC3);
    ce_pulse();
    check("stat_exit_status", status, 8'hC3);

    // program passing on second attempt
    send(C_WR1); addr(); send(C_WR2); done(1'b0); idle(1); done(1'b1);
    settle();
    check("prog_retry1_status", status, 8'h81);

    // forming timeout
    rb_low_cnt = 0;
    send(C_FM1); send(C_FM2); idle(TO_CYC);
    settle();
    check("timeout_status", status, 8'hE0);
    check("timeout_busy_cycles", rb_low_cnt, TO_CYC);

    // op_done on the timeout cycle wins
    send(C_FM1); send(C_FM2); idle(TO_CYC - 1); done(1'b0);
    settle();
    check("timeout_edge_status", status, 8'h80);

    // CE abort during erase
    send(C_ER1); addr(); send(C_ER2); idle(3);
    ce_pulse();
    check("abort_status", status, 8'h90);

    // asynchronous reset mid-program
    send(C_WR1); addr(); send(C_WR2); idle(2);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_we_rw", we_rw, 1'b0);
    check("async_rst_rb", RB, 1'b1);
    check("async_rst_status", status, 8'h80);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // RST command while loading data
    send(C_WR1); addr(); idle(1); send(C_RST);
    settle();
    check("rst_cmd_we_l", WE_L, 1'b0);

    // wrong second command leaves forming waiting for FM2
    send(C_FM1); send(C_WR2); idle(1); send(C_FM2);
    settle();
    check("bad_seq_form_rw", form_rw, 1'b1);
    done(1'b0); settle();

    // command byte without CLE is ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_READ); addr();
    settle();
    check("no_cle_re_rw", re_rw, 1'b0);
    check("no_cle_rb", RB, 1'b1);

    idle(2);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
